// File: rtl/viterbi_ctrl_seq.sv
// viterbi_ctrl_seq: control sequencer generating Viterbi datapath enables with fill/drain/trace/flush phasing
module viterbi_ctrl_seq #(
  parameter int FILL_CYCLES = 2,
  parameter int MEM_DELAY   = 8,
  parameter int FRAME_LEN   = 0,
  parameter int FLUSH_LEN   = 8,
  parameter int CNT_W       = 16,
  parameter int FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i_start,
  input  logic              i_sync,
  input  logic              i_flush,
  output logic              o_en_ce,
  output logic              o_en_s,
  output logic              o_en_acs,
  output logic              o_en_m,
  output logic              o_en_t,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic [FCNT_W-1:0] o_frame_cnt
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    TRACE = 3'd5,
    FLUSH = 3'd6,
    ILL   = 3'd7
  } state_t;
  // terminal counts: a phase lasts LEN enabled cycles, so exit fires at LEN-1
  localparam logic [CNT_W-1:0] L_FILL  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DRAIN = CNT_W'(MEM_DELAY - 1);
  localparam logic [CNT_W-1:0] L_TRACE = CNT_W'((FRAME_LEN == 0) ? 0 : FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] L_FLUSH = CNT_W'(FLUSH_LEN - 1);
  localparam logic             FRAMED  = (FRAME_LEN != 0);
  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic                r_done;
  logic                w_count;
  logic                w_done_set;
  // next-state decode; en gating is applied at the registers
  always_comb begin
    w_next     = r_state;
    w_count    = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      IDLE:  w_next = i_start ? FILL : IDLE;
      FILL: begin
        w_count = 1'b1;
        w_next  = (r_cnt == L_FILL) ? PRIME : FILL;
      end
      PRIME: w_next = RUN;
      RUN:   w_next = i_sync ? DRAIN : RUN;
      DRAIN: begin
        w_count = 1'b1;
        w_next  = (r_cnt == L_DRAIN) ? TRACE : DRAIN;
      end
      TRACE: begin
        w_count = FRAMED;
        w_next  = (i_flush || (FRAMED && r_cnt == L_TRACE)) ? FLUSH : TRACE;
      end
      FLUSH: begin
        w_count    = 1'b1;
        w_done_set = (r_cnt == L_FLUSH);
        w_next     = w_done_set ? IDLE : FLUSH;
      end
      default: w_next = IDLE;
    endcase
  end
  // state register, advances only on enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else if (en) r_state <= w_next;
  end
  // phase counter restarts on every transition; frame counter and done pulse track FLUSH exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= en & w_done_set;
      if (en) begin
        r_cnt <= (w_next != r_state) ? '0 : (w_count ? r_cnt + 1'b1 : r_cnt);
        if (w_done_set) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end
  assign o_en_ce     = r_state inside {FILL, PRIME, RUN, DRAIN, TRACE};
  assign o_en_s      = o_en_ce;
  assign o_en_acs    = r_state inside {PRIME, RUN};
  assign o_en_m      = r_state inside {RUN, DRAIN, TRACE, FLUSH};
  assign o_en_t      = r_state inside {TRACE, FLUSH};
  assign o_busy      = r_state inside {FILL, PRIME, RUN, DRAIN, TRACE, FLUSH};
  assign o_done      = r_done;
  assign o_state     = r_state;
  assign o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_viterbi_ctrl_seq.sv
// tb_viterbi_ctrl_seq: directed table and sequence checks for the Viterbi control sequencer
module tb_viterbi_ctrl_seq;
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_PRIME = 3'd2, S_RUN = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4, S_TRACE = 3'd5, S_FLUSH = 3'd6;
  logic clk = 1'b0, rst;
  logic a_en, a_start, a_sync, a_flush, a_ce, a_s, a_acs, a_m, a_t, a_busy, a_done;
  logic [2:0] a_state;
  logic [7:0] a_fc;
  logic b_en, b_start, b_sync, b_flush, b_ce, b_s, b_acs, b_m, b_t, b_busy, b_done;
  logic [2:0] b_state;
  logic [1:0] b_fc;
  int checks = 0, errors = 0;
  typedef struct {
    logic       en, start, sync, flush;
    int         n;
    logic [2:0] st;
    logic       done;
    int         fc;
  } vec_t;
  vec_t vecs[28];
  always #5 clk = ~clk;
  viterbi_ctrl_seq dut_a (
    .clk(clk), .rst(rst), .en(a_en), .i_start(a_start), .i_sync(a_sync), .i_flush(a_flush),
    .o_en_ce(a_ce), .o_en_s(a_s), .o_en_acs(a_acs), .o_en_m(a_m), .o_en_t(a_t),
    .o_busy(a_busy), .o_done(a_done), .o_state(a_state), .o_frame_cnt(a_fc)
  );
  viterbi_ctrl_seq #(.FRAME_LEN(16), .FLUSH_LEN(4), .FCNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .i_start(b_start), .i_sync(b_sync), .i_flush(b_flush),
    .o_en_ce(b_ce), .o_en_s(b_s), .o_en_acs(b_acs), .o_en_m(b_m), .o_en_t(b_t),
    .o_busy(b_busy), .o_done(b_done), .o_state(b_state), .o_frame_cnt(b_fc)
  );
  // expected {ce,s,acs,m,t,busy} for each state code
  function automatic logic [5:0] dec(input logic [2:0] st);
    case (st)
      3'd1:    return 6'b110001;
      3'd2:    return 6'b111001;
      3'd3:    return 6'b111101;
      3'd4:    return 6'b110101;
      3'd5:    return 6'b110111;
      3'd6:    return 6'b000111;
      default: return 6'b000000;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [2:0] st, input logic d, input int fc,
                     input logic [9:0] got, input int gfc);
    logic [9:0] exp;
    exp = {st, dec(st), d};
    checks++;
    if (got !== exp || gfc != fc) begin
      errors++;
      $display("FAIL %s: got state/en/busy/done=%b frame_cnt=%0d, expected %b frame_cnt=%0d",
               nm, got, gfc, exp, fc);
    end
  endtask
  task automatic chk_a(input string nm, input logic [2:0] st, input logic d, input int fc);
    chk(nm, st, d, fc, {a_state, a_ce, a_s, a_acs, a_m, a_t, a_busy, a_done}, int'(a_fc));
  endtask
  task automatic chk_b(input string nm, input logic [2:0] st, input logic d, input int fc);
    chk(nm, st, d, fc, {b_state, b_ce, b_s, b_acs, b_m, b_t, b_busy, b_done}, int'(b_fc));
  endtask
  task automatic step_a(input logic e, input logic st, input logic sy, input logic fl);
    @(negedge clk);
    a_en = e; a_start = st; a_sync = sy; a_flush = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic step_b(input logic e, input logic st, input logic sy, input logic fl);
    @(negedge clk);
    b_en = e; b_start = st; b_sync = sy; b_flush = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {a_en, a_start, a_sync, a_flush} = 4'b1000;
    {b_en, b_start, b_sync, b_flush} = 4'b1000;
    vecs[0]  = '{1, 1, 0, 0, 1,  S_FILL,  0, 0};
    vecs[1]  = '{1, 0, 1, 1, 1,  S_FILL,  0, 0};
    vecs[2]  = '{1, 0, 1, 1, 1,  S_PRIME, 0, 0};
    vecs[3]  = '{1, 0, 1, 1, 1,  S_RUN,   0, 0};
    vecs[4]  = '{1, 1, 0, 0, 3,  S_RUN,   0, 0};
    vecs[5]  = '{1, 0, 1, 0, 1,  S_DRAIN, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, 7,  S_DRAIN, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 1,  S_TRACE, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 15, S_TRACE, 0, 0};
    vecs[9]  = '{1, 0, 0, 1, 1,  S_FLUSH, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 3,  S_FLUSH, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 1,  S_IDLE,  1, 1};
    vecs[12] = '{1, 1, 0, 0, 1,  S_FILL,  0, 1};
    vecs[13] = '{1, 0, 0, 0, 1,  S_FILL,  0, 1};
    vecs[14] = '{1, 0, 0, 0, 1,  S_PRIME, 0, 1};
    vecs[15] = '{1, 0, 0, 0, 2,  S_RUN,   0, 1};
    vecs[16] = '{1, 0, 1, 0, 1,  S_DRAIN, 0, 1};
    vecs[17] = '{1, 0, 0, 0, 7,  S_DRAIN, 0, 1};
    vecs[18] = '{1, 0, 0, 0, 1,  S_TRACE, 0, 1};
    vecs[19] = '{1, 0, 0, 0, 14, S_TRACE, 0, 1};
    vecs[20] = '{0, 0, 0, 1, 4,  S_TRACE, 0, 1};
    vecs[21] = '{1, 0, 0, 0, 1,  S_TRACE, 0, 1};
    vecs[22] = '{1, 0, 0, 0, 1,  S_FLUSH, 0, 1};
    vecs[23] = '{1, 0, 0, 0, 3,  S_FLUSH, 0, 1};
    vecs[24] = '{1, 0, 0, 0, 1,  S_IDLE,  1, 2};
    vecs[25] = '{1, 0, 0, 0, 1,  S_IDLE,  0, 2};
    vecs[26] = '{0, 1, 0, 0, 2,  S_IDLE,  0, 2};
    vecs[27] = '{1, 0, 0, 0, 1,  S_IDLE,  0, 2};
    #12;
    chk_a("reset_a", S_IDLE, 0, 0);
    chk_b("reset_b", S_IDLE, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    // continuous mode: fill, prime, run until sync at cycle 10, drain 8, trace held
    step_a(1, 1, 0, 0); chk_a("cont_fill0", S_FILL, 0, 0);
    step_a(1, 0, 0, 0); chk_a("cont_fill1", S_FILL, 0, 0);
    step_a(1, 0, 0, 0); chk_a("cont_prime", S_PRIME, 0, 0);
    for (int i = 4; i < 10; i++) begin
      step_a(1, 0, 0, 0); chk_a($sformatf("cont_run%0d", i), S_RUN, 0, 0);
    end
    step_a(1, 0, 1, 0); chk_a("cont_drain0", S_DRAIN, 0, 0);
    for (int i = 1; i < 8; i++) begin
      step_a(1, 0, 0, 0); chk_a($sformatf("cont_drain%0d", i), S_DRAIN, 0, 0);
    end
    step_a(1, 0, 0, 0); chk_a("cont_trace_entry", S_TRACE, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step_a(1, 0, 0, 0); chk_a($sformatf("cont_trace_hold%0d", i), S_TRACE, 0, 0);
    end
    step_a(1, 0, 0, 1); chk_a("cont_flush0", S_FLUSH, 0, 0);
    for (int i = 1; i < 8; i++) begin
      step_a(1, 0, 0, 0); chk_a($sformatf("cont_flush%0d", i), S_FLUSH, 0, 0);
    end
    step_a(1, 0, 0, 0); chk_a("cont_done", S_IDLE, 1, 1);
    step_a(1, 0, 0, 0); chk_a("cont_done_end", S_IDLE, 0, 1);
    // en toggling through DRAIN: 8 enabled cycles spread over 16 clocks
    step_a(1, 1, 0, 0); chk_a("tog_fill", S_FILL, 0, 1);
    step_a(1, 0, 0, 0);
    step_a(1, 0, 0, 0); chk_a("tog_prime", S_PRIME, 0, 1);
    step_a(1, 0, 0, 0); chk_a("tog_run", S_RUN, 0, 1);
    step_a(1, 0, 1, 0); chk_a("tog_drain_entry", S_DRAIN, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step_a(logic'(i % 2), 0, 0, 0); chk_a($sformatf("tog_drain%0d", i), S_DRAIN, 0, 1);
    end
    step_a(1, 0, 0, 0); chk_a("tog_trace", S_TRACE, 0, 1);
    step_a(1, 0, 0, 1); chk_a("tog_flush", S_FLUSH, 0, 1);
    for (int i = 1; i < 8; i++) step_a(1, 0, 0, 0);
    step_a(1, 0, 0, 0); chk_a("tog_done", S_IDLE, 1, 2);
    // asynchronous reset in the middle of RUN
    step_a(1, 1, 0, 0);
    step_a(1, 0, 0, 0);
    step_a(1, 0, 0, 0);
    step_a(1, 0, 0, 0); chk_a("pre_reset_run", S_RUN, 0, 2);
    #2 rst = 1'b1;
    #1 chk_a("async_reset", S_IDLE, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step_a(1, 0, 0, 0); chk_a("post_reset_idle", S_IDLE, 0, 0);
    // framed mode table
    for (int v = 0; v < 28; v++)
      for (int k = 0; k < vecs[v].n; k++) begin
        step_b(vecs[v].en, vecs[v].start, vecs[v].sync, vecs[v].flush);
        chk_b($sformatf("vec%0d_%0d", v, k), vecs[v].st, vecs[v].done, vecs[v].fc);
      end
    // frame counter wrap with early flush
    for (int f = 3; f <= 5; f++) begin
      step_b(1, 1, 0, 0); chk_b($sformatf("wrap%0d_fill", f), S_FILL, 0, (f - 1) % 4);
      step_b(1, 0, 0, 0);
      step_b(1, 0, 0, 0);
      step_b(1, 0, 0, 0); chk_b($sformatf("wrap%0d_run", f), S_RUN, 0, (f - 1) % 4);
      step_b(1, 0, 1, 0);
      for (int i = 0; i < 8; i++) step_b(1, 0, 0, 0);
      chk_b($sformatf("wrap%0d_trace", f), S_TRACE, 0, (f - 1) % 4);
      step_b(1, 0, 0, 0);
      step_b(1, 0, 0, 1); chk_b($sformatf("wrap%0d_flush", f), S_FLUSH, 0, (f - 1) % 4);
      for (int i = 0; i < 3; i++) step_b(1, 0, 0, 0);
      step_b(1, 0, 0, 0); chk_b($sformatf("wrap%0d_done", f), S_IDLE, 1, f % 4);
      step_b(1, 0, 0, 0); chk_b($sformatf("wrap%0d_after", f), S_IDLE, 0, f % 4);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
